// File: rtl/acia_rx_buf_if.sv
// Host-side bundle of the buffered serial receiver: serial line in, FIFO head and status out.
interface acia_rx_buf_if #(parameter int FIFO_DEPTH = 4);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          rx_serial_i;
  logic          rx_rd_i;
  logic          clr_i;
  logic [7:0]    rx_dat_o;
  logic          rx_valid_o;
  logic          rx_ferr_o;
  logic          rx_perr_o;
  logic          rx_overrun_o;
  logic          rx_break_o;
  logic [CW-1:0] rx_count_o;

  modport master (
    output rx_serial_i, rx_rd_i, clr_i,
    input  rx_dat_o, rx_valid_o, rx_ferr_o, rx_perr_o, rx_overrun_o, rx_break_o, rx_count_o
  );
  modport slave (
    input  rx_serial_i, rx_rd_i, clr_i,
    output rx_dat_o, rx_valid_o, rx_ferr_o, rx_perr_o, rx_overrun_o, rx_break_o, rx_count_o
  );
endinterface

// File: rtl/acia_rx_buf.sv
// Asynchronous serial receiver: synchroniser/filter, framing FSM and a first-word
// fall-through receive FIFO holding {ferr, perr, data} per frame.
module acia_rx_buf #(
  parameter int CLK_HZ     = 25_125_000,
  parameter int BPS_RATE   = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_ni,
  acia_rx_buf_if.slave bus
);
  localparam int BPS_COUNT = CLK_HZ / BPS_RATE;
  localparam int TW = $clog2(BPS_COUNT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = DATA_BITS + 2;
  localparam logic [TW-1:0] T_HALF = TW'(BPS_COUNT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(BPS_COUNT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAITHI} state_t;

  // sync[0] is the newest sample; line only moves once the two oldest agree
  logic [2:0] sync;
  logic       line;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync <= 3'b111;
      line <= 1'b1;
    end else begin
      sync <= {sync[1:0], bus.rx_serial_i};
      if (sync[2] == sync[1] && sync[2] != line) line <= sync[2];
    end
  end

  state_t               state, state_nxt;
  logic [TW-1:0]        tmr, tmr_nxt;
  logic [3:0]           bitn, bitn_nxt;
  logic [DATA_BITS-1:0] shr, shr_nxt;
  logic                 par_bit, par_nxt;
  logic                 push_q, push_nxt;
  logic                 brk_q, brk_nxt;
  logic [EW-1:0]        ent_q, ent_nxt;
  logic                 expire, perr_c;

  assign expire = (tmr == '0);
  assign perr_c = (PARITY == 1) ? ~(^{shr, par_bit}) :
                  (PARITY == 2) ?  (^{shr, par_bit}) : 1'b0;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      tmr     <= '0;
      bitn    <= '0;
      shr     <= '0;
      par_bit <= 1'b0;
      push_q  <= 1'b0;
      brk_q   <= 1'b0;
      ent_q   <= '0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      bitn    <= bitn_nxt;
      shr     <= shr_nxt;
      par_bit <= par_nxt;
      push_q  <= push_nxt;
      brk_q   <= brk_nxt;
      ent_q   <= ent_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    bitn_nxt  = bitn;
    shr_nxt   = shr;
    par_nxt   = par_bit;
    push_nxt  = 1'b0;
    brk_nxt   = 1'b0;
    ent_nxt   = ent_q;
    case (state)
      IDLE: if (!line) begin
        state_nxt = START;
        tmr_nxt   = T_HALF;
      end
      START: if (!expire) tmr_nxt = tmr - 1'b1;
        else if (line) state_nxt = IDLE;
        else begin
          state_nxt = DATA;
          tmr_nxt   = T_FULL;
          bitn_nxt  = '0;
        end
      DATA: if (!expire) tmr_nxt = tmr - 1'b1;
        else begin
          shr_nxt  = {line, shr[DATA_BITS-1:1]};
          tmr_nxt  = T_FULL;
          bitn_nxt = bitn + 1'b1;
          if (bitn == 4'(DATA_BITS - 1)) state_nxt = (PARITY != 0) ? PAR : STOP;
        end
      PAR: if (!expire) tmr_nxt = tmr - 1'b1;
        else begin
          par_nxt   = line;
          tmr_nxt   = T_FULL;
          state_nxt = STOP;
        end
      STOP: if (!expire) tmr_nxt = tmr - 1'b1;
        else begin
          // error frames are still buffered; the flags travel with the data
          tmr_nxt   = T_FULL;
          push_nxt  = 1'b1;
          ent_nxt   = {~line, perr_c, shr};
          brk_nxt   = ~line && (shr == '0) && (PARITY == 0 || !par_bit);
          state_nxt = line ? IDLE : WAITHI;
        end
      WAITHI: if (line) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          ovr, full, pop, wr, ovf;

  assign full = (cnt == CW'(FIFO_DEPTH));
  assign pop  = bus.rx_rd_i && (cnt != '0);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign wr   = push_q && (!full || pop);
  assign ovf  = push_q && full && !pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= ent_q;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovr <= 1'b0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(wr) - CW'(pop);
      if (ovf)            ovr <= 1'b1;
      else if (bus.clr_i) ovr <= 1'b0;
    end
  end

  logic [EW-1:0] head;
  assign head = (cnt != '0) ? mem[rp] : '0;

  assign bus.rx_dat_o     = 8'(head[DATA_BITS-1:0]);
  assign bus.rx_ferr_o    = head[EW-1];
  assign bus.rx_perr_o    = head[EW-2];
  assign bus.rx_valid_o   = (cnt != '0);
  assign bus.rx_count_o   = cnt;
  assign bus.rx_overrun_o = ovr;
  assign bus.rx_break_o   = brk_q;
endmodule

// File: doc/acia_rx_buf.md
ACIA_RX_BUF -- requirements
Module: acia_rx_buf

Interface
- REQ-001: Parameter CLK_HZ, default 25_125_000, system clock frequency in Hz.
- REQ-002: Parameter BPS_RATE, default 115_200, serial bit rate; BPS_COUNT = CLK_HZ/BPS_RATE, integer divide.
- REQ-003: Parameter DATA_BITS, default 8, legal 5..8, data bits per frame, LSB first.
- REQ-004: Parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
- REQ-005: Parameter FIFO_DEPTH, default 4, power of two >= 2, receive buffer entries.
- REQ-006: clk  in  1  system clock, all logic on rising edge.
- REQ-007: rst_ni  in  1  asynchronous active-low reset.
- REQ-008: rx_serial_i  in  1  raw asynchronous serial input, idle high.
- REQ-009: rx_rd_i  in  1  pop head FIFO entry; ignored when rx_valid_o = 0.
- REQ-010: clr_i  in  1  clears sticky rx_overrun_o.
- REQ-011: rx_dat_o  out  8  head entry data, first-word fall-through; bits above DATA_BITS-1 are zero.
- REQ-012: rx_valid_o  out  1  FIFO not empty.
- REQ-013: rx_ferr_o  out  1  head entry framing error.
- REQ-014: rx_perr_o  out  1  head entry parity error; always 0 when PARITY = 0.
- REQ-015: rx_overrun_o  out  1  sticky: a frame was dropped because the FIFO was full.
- REQ-016: rx_break_o  out  1  one-cycle pulse when a break frame is detected.
- REQ-017: rx_count_o  out  $clog2(FIFO_DEPTH+1)  number of FIFO entries held.

Function
- REQ-018: Input SHALL pass through a 3-flop synchroniser; the filtered line state changes only when the last 2 synchronised samples agree on the opposite level.
- REQ-019: FSM states SHALL be IDLE, START, DATA, PAR, STOP, WAITHI.
- REQ-020: IDLE -> START on filtered line = 0; bit timer loads BPS_COUNT/2 - 1.
- REQ-021: START, on timer expiry, re-samples the line: 1 = false start -> IDLE with no entry; 0 -> DATA with timer = BPS_COUNT-1 and bit count = 0.
- REQ-022: Each expiry in DATA/PAR/STOP samples the filtered line and reloads BPS_COUNT-1; DATA exits after DATA_BITS samples to PAR (PARITY != 0) or STOP.
- REQ-023: Parity error = sampled parity bit != expected; odd: XOR(data, par) = 1; even: XOR(data, par) = 0.
- REQ-024: The STOP sample pushes {ferr = ~stop, perr, data} into the FIFO on the next cycle; rx_valid_o rises 1 cycle after the stop-sample cycle if the FIFO was empty.
- REQ-025: Frames with framing or parity errors SHALL still be pushed, with their flags.
- REQ-026: Break = data all zero, parity bit (if any) zero, stop = 0: pulse rx_break_o once and push entry 0x00 with ferr = 1.
- REQ-027: After a stop sample of 0, go to WAITHI and stay until filtered line = 1, then IDLE; a held-low line yields exactly one entry.
- REQ-028: Push when full with no simultaneous pop: frame dropped, FIFO unchanged, rx_overrun_o set.
- REQ-029: Simultaneous push and pop when full SHALL both take effect; count unchanged, no overrun.
- REQ-030: Pop when empty SHALL have no effect; pointers wrap modulo FIFO_DEPTH.
- REQ-031: clr_i clears overrun; if an overrun occurs in the same cycle, set wins.

Reset
- REQ-032: On rst_ni = 0, immediately: FSM IDLE, synchroniser and filtered state = 1, FIFO empty, rx_valid_o = 0, rx_count_o = 0, rx_overrun_o = 0, rx_break_o = 0, rx_dat_o = 0, rx_ferr_o = 0, rx_perr_o = 0.
- REQ-033: Reset mid-frame discards the partial frame; after release, reception starts only on a new falling edge.

Verification
- REQ-034: Default parameters (BPS_COUNT = 218), frame 0xA5 8N1 -> one entry 0xA5 with ferr = 0 and perr = 0, rx_count_o = 1, rx_valid_o high 1 cycle after the stop sample; pulse rx_rd_i -> count 0.
- REQ-035: PARITY = 2, DATA_BITS = 7, frame 0x41 with parity bit 1 -> rx_dat_o = 0x41, perr = 1; same frame with parity bit 0 -> perr = 0.
- REQ-036: 60-cycle low glitch on idle line -> no entry, FSM back to IDLE; 1-cycle glitch -> FSM never leaves IDLE.
- REQ-037: FIFO_DEPTH = 4, five frames 0x01..0x05, no reads -> count 4, entries 0x01..0x04, rx_overrun_o = 1; clr_i -> 0; pop and push in the same cycle when full -> count stays 4, no overrun.
- REQ-038: Line held low for 12 bit times, then high -> exactly one entry 0x00 with ferr = 1, one rx_break_o pulse; next frame 0x3C is received correctly.
- REQ-039: rst_ni asserted during bit 4 of a frame -> all outputs at reset values; the trailing bits produce no entry; the next full frame 0x5A is received correctly.
